// File: rtl/switch_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Bench and synthesis builds pick different debounce lengths from here.
package switch_pkg;

    localparam int NUM_SW_DEFAULT      = 10;
    localparam int DEBOUNCE_20MS_50MHZ = 1000000;
    localparam int DEBOUNCE_SIM        = 4;

    // Kind of transition a bit commits on the current edge.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, clean flop and
// one-cycle rise/fall pulses.
module debounce_bit
    import switch_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic busy,
    output logic accept
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    edge_e            evt;

    // accept is exported so the top can register change_pulse in step with the pulses.
    always_comb begin
        accept = 1'b0;
        evt    = EDGE_NONE;
        if ((s2 != clean) && (cnt == LAST)) begin
            accept = 1'b1;
            evt    = s2 ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= (evt == EDGE_RISE);
            fall <= (evt == EDGE_FALL);
            if (s2 == clean) begin
                cnt <= '0;
            end else if (accept) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW raw slide-switch pins into clean levels plus edge events
// for the switch reader peripheral.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_SW-1:0] switch_raw,
    output logic [NUM_SW-1:0] switch_clean,
    output logic [NUM_SW-1:0] switch_rise,
    output logic [NUM_SW-1:0] switch_fall,
    output logic              change_pulse,
    output logic [NUM_SW-1:0] busy
);

    logic [NUM_SW-1:0] accept;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (switch_raw[i]),
            .clean  (switch_clean[i]),
            .rise   (switch_rise[i]),
            .fall   (switch_fall[i]),
            .busy   (busy[i]),
            .accept (accept[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            change_pulse <= 1'b0;
        end else begin
            change_pulse <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: a window-based model of "stable for D synchronised samples"
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_switch_debouncer;
    import switch_pkg::*;

    localparam int N = 10;
    localparam int D = DEBOUNCE_SIM;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] switch_raw = '0;
    logic [N-1:0] switch_clean;
    logic [N-1:0] switch_rise;
    logic [N-1:0] switch_fall;
    logic         change_pulse;
    logic [N-1:0] busy;

    switch_debouncer #(
        .NUM_SW(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .switch_raw  (switch_raw),
        .switch_clean(switch_clean),
        .switch_rise (switch_rise),
        .switch_fall (switch_fall),
        .change_pulse(change_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] busy;
        logic         change;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rise9 = 0;
    int   fall9 = 0;

    // Model: synchronised samples arrive two edges late; a bit commits once its
    // last D samples all disagree with the committed level.
    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic [N-1:0] m_clean;
    logic [D-1:0] m_win [N];

    task automatic model_clear();
        m_s1    = '0;
        m_s2    = '0;
        m_clean = '0;
        for (int b = 0; b < N; b++) m_win[b] = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw_s, output exp_t e);
        int run;
        e = '0;
        if (reset_n) begin
            for (int b = 0; b < N; b++) begin
                m_win[b] = {m_win[b][D-2:0], m_s2[b]};
                run = 0;
                for (int k = 0; k < D; k++)
                    if (run == k && m_win[b][k] != m_clean[b]) run++;
                if (run == D) begin
                    e.rise[b]  = m_s2[b];
                    e.fall[b]  = !m_s2[b];
                    m_clean[b] = m_s2[b];
                end else begin
                    e.busy[b] = (run > 0);
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_s;
        end else begin
            model_clear();
        end
        e.clean  = m_clean;
        e.change = |(e.rise | e.fall);
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive raw, let the edge happen, then optionally change reset.
    task automatic applyStimulus(input logic [N-1:0] v, input logic rst_next);
        exp_t e;
        switch_raw = v;
        @(posedge clk);
        #1;
        model_edge(v, e);
        reset_n = rst_next;
        if (!rst_next) begin
            model_clear();
            e = '0;
        end
        sb.push_back(e);
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(v, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("clean",  switch_clean, e.clean);
            check("rise",   switch_rise,  e.rise);
            check("fall",   switch_fall,  e.fall);
            check("busy",   busy,         e.busy);
            check("change", N'(change_pulse), N'(e.change));
        end
        if (switch_rise[9]) rise9++;
        if (switch_fall[9]) fall9++;
    end

    initial begin
        logic [N-1:0] cur;
        model_clear();
        #1 reset_n = 1'b0;

        // Reset held with switches already up, then released.
        for (int i = 0; i < 3; i++) applyStimulus(10'h2AA, 1'b0);
        applyStimulus(10'h2AA, 1'b1);
        hold(10'h2AA, 10);

        // All bits swap in one go.
        hold(10'h155, 10);

        // Bit 9 bounces, then settles high.
        @(negedge clk);
        rise9 = 0;
        fall9 = 0;
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 10'h355 : 10'h155, 2);
        hold(10'h355, 12);
        @(negedge clk);
        #1;
        check("bounce_rise9_count", N'(rise9), N'(1));
        check("bounce_fall9_count", N'(fall9), N'(0));

        // Short glitch on bit 0 from an all-zero clean state.
        hold(10'h000, 10);
        hold(10'h001, 3);
        hold(10'h000, 8);

        // Staggered changes on bits 0 and 5.
        hold(10'h001, 2);
        hold(10'h021, 12);

        // Reset mid-qualification.
        hold(10'h000, 8);
        hold(10'h3FF, 2);
        applyStimulus(10'h3FF, 1'b0);
        #1;
        check("clean_on_reset_assert", switch_clean, 10'h000);
        applyStimulus(10'h3FF, 1'b0);
        applyStimulus(10'h3FF, 1'b1);
        hold(10'h3FF, 10);

        // Random flips, glitches and occasional resets.
        cur = N'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyStimulus(cur, 1'b0);
                applyStimulus(cur, 1'b1);
            end else if ($urandom_range(0, 19) == 0) begin
                hold(cur ^ (N'(1) << $urandom_range(0, N - 1)), $urandom_range(1, D - 1));
            end else begin
                if ($urandom_range(0, 3) == 0) cur = cur ^ (N'(1) << $urandom_range(0, N - 1));
                applyStimulus(cur, 1'b1);
            end
        end
        hold(cur, 8);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Upstream conditioning stage for the Avalon-MM switch reader peripheral. It takes the raw, asynchronous slide-switch pins and synchronises each bit into the system clock domain. It then debounces each bit independently. The stable result drives the reader's `switch` input, and the block also produces one-cycle rise/fall event pulses for optional interrupt logic.

Parameters:
- NUM_SW, 10: number of switch bits. Must match the reader's switch width.
- DEBOUNCE_CYCLES, 1000000: synchronised input must be stable for this many clocks before it is accepted (20 ms at 50 MHz). Must be ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each per-bit counter. Derived; do not override.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- switch_raw, input, NUM_SW: raw switch pins, asynchronous to clk.
- switch_clean, output, NUM_SW: debounced, registered switch state. Feeds the reader's `switch` input.
- switch_rise, output, NUM_SW: one-cycle pulse per bit when switch_clean goes 0→1.
- switch_fall, output, NUM_SW: one-cycle pulse per bit when switch_clean goes 1→0.
- change_pulse, output, 1: OR-reduction of switch_rise | switch_fall. Registered; asserted in the same cycle as the pulses.
- busy, output, NUM_SW: per bit, high while that bit's counter is non-zero (a candidate change is being qualified).

Behaviour:
- Reset (async assert, synchronous-release behaviour inside the block):
  - Both synchroniser flops, all counters, switch_clean, switch_rise, switch_fall, change_pulse and busy go to 0.
- Synchroniser: a 2-flop chain per bit, s1 <= raw, s2 <= s1. No other logic reads s1.
- Per-bit counter, evaluated every clock:
  - If s2 == clean: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: clean <= s2, cnt <= 0, and the matching rise or fall pulse is set for 1 cycle.
  - Else: cnt <= cnt+1.
- Latency: a raw change sampled at edge 1 appears on switch_clean after edge DEBOUNCE_CYCLES+2. Example: D=4 gives an update at edge 6.
- Glitch rejection: any s2 mismatch shorter than DEBOUNCE_CYCLES clocks returns cnt to 0. In that case there is no output change and no pulse.
- Bouncing input: every return of s2 to the clean value restarts qualification from 0.
- Bits are fully independent. Simultaneous changes on several bits that qualify on the same edge produce multi-bit rise/fall vectors in a single cycle with one change_pulse.
- Pulse registers default to 0 every cycle. rise and fall are never both high on the same bit.
- Reset released with a switch already high: clean starts at 0, so that bit rises after D+2 edges with a rise pulse. This is intended; software reads the post-reset state after the first change_pulse or a timeout.
- Reset asserted mid-qualification: the counter is discarded immediately, and the bit requalifies from 0 after release.
- Counters saturate by construction, so there is no wrap-around, because they reset at D-1.
- No combinational path from switch_raw to any output.

Decomposition:
- Package switch_pkg:
  - NUM_SW_DEFAULT = 10.
  - DEBOUNCE_20MS_50MHZ = 1000000.
  - DEBOUNCE_SIM = 4 (for benches).
- Sub-module debounce_bit: one bit's synchroniser, counter, clean flop, rise/fall flops and busy.
  - The top instantiates NUM_SW copies in a generate loop and registers the change_pulse OR.

Test Plan (DEBOUNCE_CYCLES=4; the cycle count is referenced to the first edge sampling the new raw value):
1. Reset hold with switch_raw=0x2AA, then release → all outputs 0 during reset. After release, switch_clean=0x2AA at edge 6, switch_rise=0x2AA and change_pulse=1 for exactly one cycle.
2. From clean=0x000, raw=0x001 held 3 cycles then back to 0 → switch_clean stays 0x000, no pulses, busy[0] high then returns low.
3. From clean=0x2AA, raw=0x155 held → at edge 6, switch_clean=0x155, switch_rise=0x155 and switch_fall=0x2AA in the same cycle, single change_pulse.
4. Bit 9 toggled every 2 cycles for 20 cycles, then held high → exactly one switch_rise[9] pulse, 6 edges after the final transition. No fall pulses.
5. raw=0x3FF driven, then reset_n asserted at edge 3 and released 2 cycles later → clean=0x000 immediately on assert. Requalification gives clean=0x3FF 6 edges after release, with one rise pulse of 0x3FF.
6. Bit 0 changes at cycle t and bit 5 at t+2 → switch_rise=0x001 at t+6 and switch_rise=0x020 at t+8, as two separate change_pulse cycles.
